// File: rtl/alu_rs_pkg.sv
// Shared widths and the reservation-station entry layout for the ALU issue scheduler.
package alu_rs_pkg;

    localparam int ROB_IDX_W           = 4;
    localparam int DATA_W              = 32;
    localparam int OP_W                = 6;
    localparam int DEFAULT_NUM_ENTRIES = 4;
    localparam int STALL_CNT_W         = 32;

    typedef struct packed {
        logic                 valid;
        logic [OP_W-1:0]      op;
        logic                 a_rdy;
        logic [ROB_IDX_W-1:0] a_tag;
        logic [DATA_W-1:0]    a_val;
        logic                 b_rdy;
        logic [ROB_IDX_W-1:0] b_tag;
        logic [DATA_W-1:0]    b_val;
        logic [DATA_W-1:0]    imm;
        logic [DATA_W-1:0]    pc;
        logic [ROB_IDX_W-1:0] dest;
    } alu_rs_entry_t;

endpackage

// File: rtl/rr_picker.sv
// Round-robin priority picker: grants the first requester at or after ptr, wrapping around.
module rr_picker #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             any
);

    logic [IDX_W-1:0] idx;
    logic             found;

    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = '0;
        for (int i = 0; i < N; i++) begin
            idx = ptr + IDX_W'(i);
            if (!found && req[idx]) begin
                found       = 1'b1;
                grant_idx   = idx;
                grant[idx]  = 1'b1;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/alu_rs_issue_scheduler.sv
// Integer ALU reservation station: dispatch into free entries, CDB wakeup, round-robin issue.
// Optional: define ALU_RS_STALL_CNT_EN to add saturating issue/dispatch stall counters.
module alu_rs_issue_scheduler
    import alu_rs_pkg::*;
#(
    parameter int NUM_ENTRIES = DEFAULT_NUM_ENTRIES
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 disp_valid,
    output logic                 disp_ready,
    input  logic [OP_W-1:0]      disp_op,
    input  logic                 disp_a_rdy,
    input  logic                 disp_b_rdy,
    input  logic [ROB_IDX_W-1:0] disp_a_tag,
    input  logic [ROB_IDX_W-1:0] disp_b_tag,
    input  logic [DATA_W-1:0]    disp_a_data,
    input  logic [DATA_W-1:0]    disp_b_data,
    input  logic [DATA_W-1:0]    disp_imm,
    input  logic [DATA_W-1:0]    disp_pc,
    input  logic [ROB_IDX_W-1:0] disp_dest_rob,
    input  logic                 cdb_valid,
    input  logic [ROB_IDX_W-1:0] cdb_rob_index,
    input  logic [DATA_W-1:0]    cdb_data,
    output logic                 iss_valid,
    input  logic                 iss_ready,
    output logic [OP_W-1:0]      iss_op,
    output logic [DATA_W-1:0]    iss_a,
    output logic [DATA_W-1:0]    iss_b,
    output logic [DATA_W-1:0]    iss_imm,
    output logic [DATA_W-1:0]    iss_pc,
    output logic [ROB_IDX_W-1:0] iss_dest_rob
`ifdef ALU_RS_STALL_CNT_EN
    ,
    output logic [STALL_CNT_W-1:0] stall_iss_cnt,
    output logic [STALL_CNT_W-1:0] stall_disp_cnt
`endif
);

    localparam int IDX_W = $clog2(NUM_ENTRIES);

    alu_rs_entry_t          entries_q [NUM_ENTRIES];
    alu_rs_entry_t          entries_d [NUM_ENTRIES];
    logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [NUM_ENTRIES-1:0] eligible;
    logic [NUM_ENTRIES-1:0] grant;
    logic [IDX_W-1:0]       sel_idx;
    logic [IDX_W-1:0]       free_idx;
    logic [IDX_W-1:0]       out_idx;
    logic                   any_eligible;
    logic                   issue_fire;
    logic                   disp_fire;
    alu_rs_entry_t          disp_entry;

    // Free-slot search and eligibility look only at registered state.
    always_comb begin
        eligible   = '0;
        free_idx   = '0;
        disp_ready = 1'b0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            eligible[i] = entries_q[i].valid && entries_q[i].a_rdy && entries_q[i].b_rdy;
            if (!entries_q[i].valid) begin
                free_idx   = IDX_W'(i);
                disp_ready = 1'b1;
            end
        end
    end

    rr_picker #(
        .N     (NUM_ENTRIES),
        .IDX_W (IDX_W)
    ) u_picker (
        .req       (eligible),
        .ptr       (rr_ptr_q),
        .grant     (grant),
        .grant_idx (sel_idx),
        .any       (any_eligible)
    );

    assign issue_fire = any_eligible && iss_ready;
    assign disp_fire  = disp_valid && disp_ready;

    // A not-ready operand whose producer broadcasts this very cycle is captured ready.
    always_comb begin
        disp_entry       = '0;
        disp_entry.valid = 1'b1;
        disp_entry.op    = disp_op;
        disp_entry.a_rdy = disp_a_rdy || (cdb_valid && cdb_rob_index == disp_a_tag);
        disp_entry.a_tag = disp_a_tag;
        disp_entry.a_val = disp_a_rdy ? disp_a_data : cdb_data;
        disp_entry.b_rdy = disp_b_rdy || (cdb_valid && cdb_rob_index == disp_b_tag);
        disp_entry.b_tag = disp_b_tag;
        disp_entry.b_val = disp_b_rdy ? disp_b_data : cdb_data;
        disp_entry.imm   = disp_imm;
        disp_entry.pc    = disp_pc;
        disp_entry.dest  = disp_dest_rob;
    end

    always_comb begin
        entries_d = entries_q;
        rr_ptr_d  = rr_ptr_q;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (entries_q[i].valid && cdb_valid) begin
                if (!entries_q[i].a_rdy && entries_q[i].a_tag == cdb_rob_index) begin
                    entries_d[i].a_rdy = 1'b1;
                    entries_d[i].a_val = cdb_data;
                end
                if (!entries_q[i].b_rdy && entries_q[i].b_tag == cdb_rob_index) begin
                    entries_d[i].b_rdy = 1'b1;
                    entries_d[i].b_val = cdb_data;
                end
            end
            if (issue_fire && grant[i]) begin
                entries_d[i].valid = 1'b0;
            end
        end
        if (issue_fire) begin
            rr_ptr_d = sel_idx + IDX_W'(1);
        end
        // The free slot comes from current state, so it never collides with the issuing entry.
        if (disp_fire) begin
            entries_d[free_idx] = disp_entry;
        end
        if (flush) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                entries_d[i].valid = 1'b0;
            end
            rr_ptr_d = rr_ptr_q;
        end
    end

    // NOTE: the entry array is reset in full, not just the valid bits, so iss_* read zero after reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                entries_q[i] <= '0;
            end
            rr_ptr_q <= '0;
        end else begin
            entries_q <= entries_d;
            rr_ptr_q  <= rr_ptr_d;
        end
    end

    assign out_idx      = any_eligible ? sel_idx : rr_ptr_q;
    assign iss_valid    = any_eligible;
    assign iss_op       = entries_q[out_idx].op;
    assign iss_a        = entries_q[out_idx].a_val;
    assign iss_b        = entries_q[out_idx].b_val;
    assign iss_imm      = entries_q[out_idx].imm;
    assign iss_pc       = entries_q[out_idx].pc;
    assign iss_dest_rob = entries_q[out_idx].dest;

`ifdef ALU_RS_STALL_CNT_EN
    logic [STALL_CNT_W-1:0] stall_iss_cnt_q, stall_iss_cnt_d;
    logic [STALL_CNT_W-1:0] stall_disp_cnt_q, stall_disp_cnt_d;

    always_comb begin
        stall_iss_cnt_d  = stall_iss_cnt_q;
        stall_disp_cnt_d = stall_disp_cnt_q;
        if (iss_valid && !iss_ready && stall_iss_cnt_q != '1) begin
            stall_iss_cnt_d = stall_iss_cnt_q + STALL_CNT_W'(1);
        end
        if (disp_valid && !disp_ready && stall_disp_cnt_q != '1) begin
            stall_disp_cnt_d = stall_disp_cnt_q + STALL_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_iss_cnt_q  <= '0;
            stall_disp_cnt_q <= '0;
        end else begin
            stall_iss_cnt_q  <= stall_iss_cnt_d;
            stall_disp_cnt_q <= stall_disp_cnt_d;
        end
    end

    assign stall_iss_cnt  = stall_iss_cnt_q;
    assign stall_disp_cnt = stall_disp_cnt_q;
`endif

endmodule

// File: tb/tb_alu_rs_issue_scheduler.sv
// Self-checking bench for alu_rs_issue_scheduler: directed scenarios, then random traffic
// compared every cycle against a behavioural slot-array model.
module tb_alu_rs_issue_scheduler;
    import alu_rs_pkg::*;

    localparam int N = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst_n, flush, disp_valid, disp_ready;
    logic [OP_W-1:0]      disp_op;
    logic                 disp_a_rdy, disp_b_rdy;
    logic [ROB_IDX_W-1:0] disp_a_tag, disp_b_tag, disp_dest_rob;
    logic [DATA_W-1:0]    disp_a_data, disp_b_data, disp_imm, disp_pc;
    logic                 cdb_valid;
    logic [ROB_IDX_W-1:0] cdb_rob_index;
    logic [DATA_W-1:0]    cdb_data;
    logic                 iss_valid, iss_ready;
    logic [OP_W-1:0]      iss_op;
    logic [DATA_W-1:0]    iss_a, iss_b, iss_imm, iss_pc;
    logic [ROB_IDX_W-1:0] iss_dest_rob;
`ifdef ALU_RS_STALL_CNT_EN
    logic [31:0]          stall_iss_cnt, stall_disp_cnt;
`endif

    alu_rs_issue_scheduler #(.NUM_ENTRIES(N)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush         (flush),
        .disp_valid    (disp_valid),
        .disp_ready    (disp_ready),
        .disp_op       (disp_op),
        .disp_a_rdy    (disp_a_rdy),
        .disp_b_rdy    (disp_b_rdy),
        .disp_a_tag    (disp_a_tag),
        .disp_b_tag    (disp_b_tag),
        .disp_a_data   (disp_a_data),
        .disp_b_data   (disp_b_data),
        .disp_imm      (disp_imm),
        .disp_pc       (disp_pc),
        .disp_dest_rob (disp_dest_rob),
        .cdb_valid     (cdb_valid),
        .cdb_rob_index (cdb_rob_index),
        .cdb_data      (cdb_data),
        .iss_valid     (iss_valid),
        .iss_ready     (iss_ready),
        .iss_op        (iss_op),
        .iss_a         (iss_a),
        .iss_b         (iss_b),
        .iss_imm       (iss_imm),
        .iss_pc        (iss_pc),
        .iss_dest_rob  (iss_dest_rob)
`ifdef ALU_RS_STALL_CNT_EN
        ,
        .stall_iss_cnt  (stall_iss_cnt),
        .stall_disp_cnt (stall_disp_cnt)
`endif
    );

    int n_pass  = 0;
    int n_total = 0;

    // Behavioural model: one slot per entry plus a rotating start position.
    bit          m_valid [N];
    bit          m_ardy  [N];
    bit          m_brdy  [N];
    int unsigned m_op    [N];
    int unsigned m_atag  [N];
    int unsigned m_btag  [N];
    int unsigned m_a     [N];
    int unsigned m_b     [N];
    int unsigned m_imm   [N];
    int unsigned m_pc    [N];
    int unsigned m_dest  [N];
    int          m_ptr;
    longint      m_stall_iss, m_stall_disp;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_sel();
        for (int k = 0; k < N; k++) begin
            int j;
            j = (m_ptr + k) % N;
            if (m_valid[j] && m_ardy[j] && m_brdy[j]) return j;
        end
        return -1;
    endfunction

    function automatic int model_free();
        for (int i = 0; i < N; i++) begin
            if (!m_valid[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_step();
        int sel;
        int fr;
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                m_valid[i] = 0; m_ardy[i] = 0; m_brdy[i] = 0;
                m_op[i] = 0; m_atag[i] = 0; m_btag[i] = 0; m_a[i] = 0; m_b[i] = 0;
                m_imm[i] = 0; m_pc[i] = 0; m_dest[i] = 0;
            end
            m_ptr = 0;
            m_stall_iss = 0;
            m_stall_disp = 0;
        end else begin
            sel = model_sel();
            fr  = model_free();
            if (sel >= 0 && !iss_ready && m_stall_iss < 64'hFFFF_FFFF) m_stall_iss++;
            if (disp_valid && fr < 0 && m_stall_disp < 64'hFFFF_FFFF) m_stall_disp++;
            for (int i = 0; i < N; i++) begin
                if (m_valid[i] && cdb_valid) begin
                    if (!m_ardy[i] && m_atag[i] == cdb_rob_index) begin m_ardy[i] = 1; m_a[i] = cdb_data; end
                    if (!m_brdy[i] && m_btag[i] == cdb_rob_index) begin m_brdy[i] = 1; m_b[i] = cdb_data; end
                end
            end
            if (sel >= 0 && iss_ready) begin
                m_valid[sel] = 0;
                if (!flush) m_ptr = (sel + 1) % N;
            end
            if (disp_valid && fr >= 0) begin
                m_valid[fr] = 1;
                m_op[fr]    = disp_op;
                m_atag[fr]  = disp_a_tag;
                m_btag[fr]  = disp_b_tag;
                m_imm[fr]   = disp_imm;
                m_pc[fr]    = disp_pc;
                m_dest[fr]  = disp_dest_rob;
                m_ardy[fr]  = disp_a_rdy || (cdb_valid && cdb_rob_index == disp_a_tag);
                m_brdy[fr]  = disp_b_rdy || (cdb_valid && cdb_rob_index == disp_b_tag);
                m_a[fr]     = disp_a_rdy ? disp_a_data : cdb_data;
                m_b[fr]     = disp_b_rdy ? disp_b_data : cdb_data;
            end
            if (flush) begin
                for (int i = 0; i < N; i++) m_valid[i] = 0;
            end
        end
    endtask

    task automatic compare_all();
        int sel;
        sel = model_sel();
        check("disp_ready", disp_ready, model_free() >= 0);
        check("iss_valid", iss_valid, sel >= 0);
        if (sel >= 0) begin
            check("iss_op",   iss_op,       m_op[sel]);
            check("iss_a",    iss_a,        m_a[sel]);
            check("iss_b",    iss_b,        m_b[sel]);
            check("iss_imm",  iss_imm,      m_imm[sel]);
            check("iss_pc",   iss_pc,       m_pc[sel]);
            check("iss_dest", iss_dest_rob, m_dest[sel]);
        end
`ifdef ALU_RS_STALL_CNT_EN
        check("stall_iss_cnt",  stall_iss_cnt,  m_stall_iss);
        check("stall_disp_cnt", stall_disp_cnt, m_stall_disp);
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic set_disp(input bit v, input int unsigned op, input bit ar, input int unsigned at,
                            input int unsigned ad, input bit br, input int unsigned bt,
                            input int unsigned bd, input int unsigned dest);
        disp_valid    = v;
        disp_op       = OP_W'(op);
        disp_a_rdy    = ar;
        disp_a_tag    = ROB_IDX_W'(at);
        disp_a_data   = ad;
        disp_b_rdy    = br;
        disp_b_tag    = ROB_IDX_W'(bt);
        disp_b_data   = bd;
        disp_imm      = 32'h100 + ad;
        disp_pc       = 32'h4000 + (dest << 2);
        disp_dest_rob = ROB_IDX_W'(dest);
    endtask

    task automatic set_cdb(input bit v, input int unsigned idx, input int unsigned data);
        cdb_valid     = v;
        cdb_rob_index = ROB_IDX_W'(idx);
        cdb_data      = data;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; iss_ready = 1'b1;
        set_disp(0, 0, 0, 0, 0, 0, 0, 0, 0);
        set_cdb(0, 0, 0);

        // Reset state
        tick(); tick();
        check("rst_disp_ready", disp_ready, 1'b1);
        check("rst_iss_valid", iss_valid, 1'b0);
        check("rst_iss_a", iss_a, 32'h0);
        check("rst_iss_dest", iss_dest_rob, 4'h0);
        rst_n = 1'b1;

        // Both operands ready: issuable next cycle
        set_disp(1, 6'h01, 1, 0, 32'h5, 1, 0, 32'h3, 4);
        tick();
        set_disp(0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("t1_iss_valid", iss_valid, 1'b1);
        check("t1_iss_a", iss_a, 32'h5);
        check("t1_iss_b", iss_b, 32'h3);
        check("t1_iss_dest", iss_dest_rob, 4'h4);
        tick();
        check("t1_freed", iss_valid, 1'b0);

        // Wakeup from CDB three cycles after dispatch
        set_disp(1, 6'h02, 0, 7, 0, 1, 0, 32'h11, 5);
        tick();
        set_disp(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick(); tick();
        check("t2_waiting", iss_valid, 1'b0);
        set_cdb(1, 7, 32'hDEADBEEF);
        tick();
        set_cdb(0, 0, 0);
        check("t2_iss_valid", iss_valid, 1'b1);
        check("t2_iss_a", iss_a, 32'hDEADBEEF);
        tick();

        // Same-cycle dispatch/CDB bypass
        set_disp(1, 6'h03, 0, 9, 0, 1, 0, 32'h22, 6);
        set_cdb(1, 9, 32'h1234);
        tick();
        set_disp(0, 0, 0, 0, 0, 0, 0, 0, 0);
        set_cdb(0, 0, 0);
        check("t3_iss_valid", iss_valid, 1'b1);
        check("t3_iss_a", iss_a, 32'h1234);
        tick();

        // Fill all entries with the ALU stalled, then drain in round-robin order
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        iss_ready = 1'b0;
        for (int i = 0; i < N; i++) begin
            set_disp(1, 6'h10 + i, 1, 0, 32'h10 + i, 1, 0, 32'h20 + i, 8 + i);
            tick();
        end
        set_disp(0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("t4_full", disp_ready, 1'b0);
        for (int i = 0; i < 7; i++) tick();
        check("t4_held_valid", iss_valid, 1'b1);
        check("t4_held_a", iss_a, 32'h10);
`ifdef ALU_RS_STALL_CNT_EN
        check("t6_stall_iss", stall_iss_cnt, 32'd10);
        check("t6_stall_disp", stall_disp_cnt, 32'd0);
`endif
        iss_ready = 1'b1;
        for (int i = 0; i < N; i++) begin
            check("t4_order_a", iss_a, 32'h10 + i);
            tick();
            check("t4_disp_ready", disp_ready, 1'b1);
        end
        check("t4_drained", iss_valid, 1'b0);

        // Flush with waiting entries and a same-cycle dispatch
        for (int i = 1; i <= 3; i++) begin
            set_disp(1, 6'h20, 0, i, 0, 1, 0, 32'h7, i);
            tick();
        end
        set_disp(1, 6'h21, 1, 0, 32'h55, 1, 0, 32'h66, 12);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        set_disp(0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("t5_disp_ready", disp_ready, 1'b1);
        check("t5_iss_valid", iss_valid, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            set_cdb(1, i, 32'hAB00 + i);
            tick();
            check("t5_no_issue", iss_valid, 1'b0);
        end
        set_cdb(0, 0, 0);

        // Random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            rst_n     = ($urandom_range(0, 149) != 0);
            flush     = ($urandom_range(0, 39) == 0);
            iss_ready = ($urandom_range(0, 9) < 6);
            set_disp($urandom_range(0, 1), $urandom_range(0, 63),
                     $urandom_range(0, 2) != 0, $urandom_range(0, 3), $urandom,
                     $urandom_range(0, 2) != 0, $urandom_range(0, 3), $urandom,
                     $urandom_range(0, 15));
            set_cdb($urandom_range(0, 1), $urandom_range(0, 3), $urandom);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
